// File: rtl/example_mul8.sv
// Sequential WIDTH x WIDTH unsigned shift-add multiplier with busy/done.
// Ports: clk, reset (async high), A/B operands, C start, P product, busy, done.
module example_mul8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               C,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               start;
  logic               last;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic; C is only looked at while idle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (C)    state_nx = RUN;
      RUN:  if (last) state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // decoded outputs / strobes
  always_comb begin
    busy  = 1'b0;
    start = 1'b0;
    last  = 1'b0;
    unique case (state)
      IDLE: start = C;
      RUN: begin
        busy = 1'b1;
        last = (cnt == LAST);
      end
      default: ;
    endcase
  end

  // partial product for this step; the sum never exceeds 2*WIDTH bits
  always_comb begin
    acc_sum = acc;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end
  end

  // datapath; P is written only on the final step so it never shows
  // a partial sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= {{WIDTH{1'b0}}, A};
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end else if (busy) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          P    <= acc_sum;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_example_mul8.sv
// Self-checking bench for example_mul8: vector table, random ops
// against a plain a*b model, and hand-written timing corner cases.
module tb_example_mul8;

  logic        clk;
  logic        reset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        C;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tbl [6];

  example_mul8 #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .C    (C),
    .P    (P),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  // One operation with fixed-latency checks. With junk=1, A/B/C are
  // scrambled during the run; none of it may affect the result.
  task automatic run_op(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] want,
                        input bit junk);
    logic [15:0] prev;
    @(negedge clk);
    A = a;
    B = b;
    C = 1'b1;
    prev = P;
    @(negedge clk);
    C = 1'b0;
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_done", 16'(done), 16'd0);
    for (int i = 1; i <= 8; i++) begin
      if (junk) begin
        A = 8'($urandom);
        B = 8'($urandom);
        C = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (i < 8) begin
        chk("run_busy", 16'(busy), 16'd1);
        chk("run_done", 16'(done), 16'd0);
        chk("run_p_hold", P, prev);
      end else begin
        chk("fin_done", 16'(done), 16'd1);
        chk("fin_busy", 16'(busy), 16'd0);
        chk("fin_p", P, want);
      end
    end
    C = 1'b0;
    @(negedge clk);
    chk("post_done", 16'(done), 16'd0);
    chk("post_busy", 16'(busy), 16'd0);
    chk("post_p", P, want);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rp;
    total = 0;
    bad   = 0;

    tbl[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    tbl[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    tbl[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
    tbl[4] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    tbl[5] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};

    // reset behaviour
    reset = 1'b1;
    A = '0;
    B = '0;
    C = 1'b0;
    #100;
    chk("rst_p", P, 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 16'(busy), 16'd0);
      chk("idle_done", 16'(done), 16'd0);
      chk("idle_p", P, 16'd0);
    end

    // directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].p, 1'b0);
    end

    // start ignored mid-run, operand changes ignored
    @(negedge clk);
    A = 8'd7;
    B = 8'd9;
    C = 1'b1;
    @(negedge clk);
    C = 1'b0;
    chk("ign_busy", 16'(busy), 16'd1);
    repeat (2) @(negedge clk);
    A = 8'd1;
    B = 8'd1;
    C = 1'b1;
    @(negedge clk);
    C = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("ign_run", 16'(busy), 16'd1);
    end
    @(negedge clk);
    chk("ign_done", 16'(done), 16'd1);
    chk("ign_p", P, 16'd63);
    @(negedge clk);
    chk("ign_idle", 16'(busy), 16'd0);

    // asynchronous reset mid-operation
    A = 8'd100;
    B = 8'd3;
    C = 1'b1;
    @(negedge clk);
    C = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_p", P, 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_done", 16'(done), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_idle", 16'(busy), 16'd0);
    run_op(8'd2, 8'd5, 16'd10, 1'b0);

    // C held high: back-to-back ops every 9 cycles
    @(negedge clk);
    A = 8'd3;
    B = 8'd4;
    C = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("b2b_busy", 16'(busy), 16'd1);
        chk("b2b_nodone", 16'(done), 16'd0);
      end
      @(negedge clk);
      chk("b2b_done", 16'(done), 16'd1);
      chk("b2b_p", P, 16'd12);
    end
    C = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_stop", 16'(busy), 16'd0);

    // random operations with scrambled inputs during the run
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = 16'(int'(ra) * int'(rb));
      run_op(ra, rb, rp, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
